// File: rtl/instr_fetch_unit.sv
// Fetch stage between the program counter and decode: it requests instructions
// from the I-cache, buffers them in order, and tells the PC when to advance.
module instr_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pcaddr,
  input  logic [31:0] nxt_pc,
  output logic        pc_advance,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [31:0] imemload,
  input  logic        ihit,
  input  logic        flush,
  input  logic        halt,
  input  logic        id_ready,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc,
  output logic        fetch_busy
);

  // state   | meaning
  // IDLE    | first cycle out of reset, no request issued
  // RUN     | fetching whenever the buffer has room
  // HALTED  | fetch stopped for good; buffer only drains (left by RST only)
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] npc_q   [DEPTH];

  logic push;
  logic pop;

  // The request never looks at id_ready, so decode has no path to the cache.
  assign imemREN    = (state_q == S_RUN) && (count_q < FULL_CNT) && !halt;
  assign imemaddr   = pcaddr;
  assign push       = imemREN && ihit && !flush;
  assign pc_advance = push;
  assign fetch_busy = imemREN && !ihit;

  assign ifid_valid = (count_q != '0);
  assign pop        = ifid_valid && id_ready && !flush;

  assign ifid_instr = ifid_valid ? instr_q[rd_ptr_q] : '0;
  assign ifid_pc    = ifid_valid ? pc_q[rd_ptr_q]    : '0;
  assign ifid_npc   = ifid_valid ? npc_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_RUN;
      S_RUN:    state_d = halt ? S_HALTED : S_RUN;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_q[wr_ptr_q] <= imemload;
      pc_q[wr_ptr_q]    <= pcaddr;
      npc_q[wr_ptr_q]   <= nxt_pc;
    end
  end

endmodule
